// File: rtl/id_rm_issue_pkg.sv
// Shared decode constants and helpers for the R/M-type decode-and-issue stage.
package id_rm_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam int         ZERO_REG   = 0;
  localparam logic       READ_EN    = 1'b1;
  localparam logic       WRITE_EN   = 1'b1;

  typedef enum logic [1:0] {
    F7_CLASS_BASE,
    F7_CLASS_ALT,
    F7_CLASS_M,
    F7_CLASS_BAD
  } f7_class_e;

  // The alternate encoding (sub/sra) exists only for funct3 000 and 101.
  function automatic f7_class_e classify_f7(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic m_en);
    if (f7 == F7_BASE) return F7_CLASS_BASE;
    if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SR)) return F7_CLASS_ALT;
    if (f7 == F7_MULDIV && m_en) return F7_CLASS_M;
    return F7_CLASS_BAD;
  endfunction

  function automatic logic [4:0] make_alu_op(input logic is_m, input logic f7_b5,
                                             input logic [2:0] f3);
    return {is_m, f7_b5, f3};
  endfunction

endpackage

// File: rtl/id_rm_issue_if.sv
// Dispatch, register-file read, EX issue and write-back signals of the issue stage.
interface id_rm_issue_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int INST_W  = 32
);
    logic               flush_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [INST_W-1:0]  inst_i;
    logic [RADDR_W-1:0] reg1_raddr_o;
    logic [RADDR_W-1:0] reg2_raddr_o;
    logic               reg1_re_o;
    logic               reg2_re_o;
    logic [DATA_W-1:0]  reg1_rdata_i;
    logic [DATA_W-1:0]  reg2_rdata_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  op1_o;
    logic [DATA_W-1:0]  op2_o;
    logic               reg_we_o;
    logic [RADDR_W-1:0] reg_waddr_o;
    logic [4:0]         alu_op_o;
    logic               is_muldiv_o;
    logic               illegal_o;
    logic               wb_valid_i;
    logic [RADDR_W-1:0] wb_waddr_i;

    modport master (
        input  flush_i, in_valid_i, inst_i, reg1_rdata_i, reg2_rdata_i,
               out_ready_i, wb_valid_i, wb_waddr_i,
        output in_ready_o, reg1_raddr_o, reg2_raddr_o, reg1_re_o, reg2_re_o,
               out_valid_o, op1_o, op2_o, reg_we_o, reg_waddr_o, alu_op_o,
               is_muldiv_o, illegal_o
    );

    modport slave (
        output flush_i, in_valid_i, inst_i, reg1_rdata_i, reg2_rdata_i,
               out_ready_i, wb_valid_i, wb_waddr_i,
        input  in_ready_o, reg1_raddr_o, reg2_raddr_o, reg1_re_o, reg2_re_o,
               out_valid_o, op1_o, op2_o, reg_we_o, reg_waddr_o, alu_op_o,
               is_muldiv_o, illegal_o
    );
endinterface

// File: rtl/id_rm_issue_scoreboard.sv
// Busy-bit scoreboard for in-flight MUL/DIV destinations (only built with ID_M_EXT_EN).
module id_scoreboard #(
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_en,
    input  logic [RADDR_W-1:0] set_addr,
    input  logic               clr_en,
    input  logic [RADDR_W-1:0] clr_addr,
    input  logic [RADDR_W-1:0] rs1,
    input  logic [RADDR_W-1:0] rs2,
    input  logic [RADDR_W-1:0] rd,
    output logic               hazard
);
    localparam int DEPTH = 2 ** RADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        // NOTE: busy_d takes its default before any conditional update, so no latch is inferred.
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the busy vector is control state, not data storage, so it must reset to all-free.
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // Only the registered vector is consulted: a write-back frees its register one cycle later.
    assign hazard = (rs1 != '0 && busy_q[rs1]) ||
                    (rs2 != '0 && busy_q[rs2]) ||
                    (rd  != '0 && busy_q[rd]);
endmodule

// File: rtl/id_rm_issue.sv
// Registered R/M-type decode-and-issue stage with a one-entry output register.
// Build option ID_M_EXT_EN enables the M extension and its hazard scoreboard.
module id_rm_issue
    import id_rm_issue_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int INST_W  = 32
) (
    input logic           clk,
    input logic           rst_n,
    id_rm_issue_if.master bus
);
`ifdef ID_M_EXT_EN
    localparam logic M_EN = 1'b1;
`else
    localparam logic M_EN = 1'b0;
`endif

    logic [INST_W-1:0]  inst;
    logic [6:0]         opcode;
    logic [6:0]         f7;
    logic [2:0]         f3;
    logic [RADDR_W-1:0] rd, rs1, rs2;
    f7_class_e          f7_class;
    logic               is_op, is_m, legal, hazard, in_ready, load, sb_set;

    logic               out_valid_q, reg_we_q, is_muldiv_q, illegal_q;
    logic [DATA_W-1:0]  op1_q, op2_q;
    logic [RADDR_W-1:0] reg_waddr_q;
    logic [4:0]         alu_op_q;

    assign inst   = bus.inst_i;
    assign opcode = inst[6:0];
    assign rd     = inst[7 +: RADDR_W];
    assign f3     = inst[14:12];
    assign rs1    = inst[15 +: RADDR_W];
    assign rs2    = inst[20 +: RADDR_W];
    assign f7     = inst[31:25];

    always_comb begin
        is_op    = (opcode == OPC_OP);
        f7_class = classify_f7(f7, f3, M_EN);
        is_m     = (f7_class == F7_CLASS_M);
        legal    = (f7_class != F7_CLASS_BAD);
    end

`ifdef ID_M_EXT_EN
    assign sb_set = load && legal && is_m && (rd != RADDR_W'(ZERO_REG));

    id_scoreboard #(.RADDR_W(RADDR_W)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_addr (rd),
        .clr_en   (bus.wb_valid_i),
        .clr_addr (bus.wb_waddr_i),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .hazard   (hazard)
    );
`else
    logic unused_wb;
    assign sb_set    = 1'b0;
    assign hazard    = 1'b0;
    assign unused_wb = ^{bus.wb_valid_i, bus.wb_waddr_i, sb_set};
`endif

    // Flush wins over a same-cycle accept; non-OP opcodes are consumed without loading.
    assign in_ready = !bus.flush_i && (!out_valid_q || bus.out_ready_i) && !(is_op && hazard);
    assign load     = bus.in_valid_i && in_ready && is_op;

    assign bus.in_ready_o   = in_ready;
    assign bus.reg1_re_o    = (bus.in_valid_i && is_op) ? READ_EN : !READ_EN;
    assign bus.reg2_re_o    = (bus.in_valid_i && is_op) ? READ_EN : !READ_EN;
    assign bus.reg1_raddr_o = (bus.in_valid_i && is_op) ? rs1 : '0;
    assign bus.reg2_raddr_o = (bus.in_valid_i && is_op) ? rs2 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments everywhere here so every flop samples pre-edge values.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            alu_op_q    <= '0;
            is_muldiv_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (bus.flush_i) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            reg_waddr_q <= rd;
            alu_op_q    <= make_alu_op(is_m, f7[5], f3);
            illegal_q   <= !legal;
            is_muldiv_q <= legal && is_m;
            reg_we_q    <= legal && (rd != RADDR_W'(ZERO_REG)) ? WRITE_EN : !WRITE_EN;
            op1_q       <= legal ? bus.reg1_rdata_i : '0;
            op2_q       <= legal ? bus.reg2_rdata_i : '0;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.op1_o       = op1_q;
    assign bus.op2_o       = op2_q;
    assign bus.reg_we_o    = reg_we_q;
    assign bus.reg_waddr_o = reg_waddr_q;
    assign bus.alu_op_o    = alu_op_q;
    assign bus.is_muldiv_o = is_muldiv_q;
    assign bus.illegal_o   = illegal_q;
endmodule

// File: tb/tb_id_rm_issue.sv
// Scoreboard bench for id_rm_issue; M-extension scenarios run when ID_M_EXT_EN is defined.
module tb_id_rm_issue;
    import id_rm_issue_pkg::*;

    typedef struct {
        logic        illegal;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        we;
        logic [4:0]  waddr;
        logic [4:0]  alu;
        logic        muldiv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t exq[$];

    id_rm_issue_if bus ();

    id_rm_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Register file model: x0=0, x1=5, x2=7, otherwise 100*index.
    function automatic logic [31:0] rf(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a == 5'd1) return 32'd5;
        if (a == 5'd2) return 32'd7;
        return {27'd0, a} * 32'd100;
    endfunction

    assign bus.reg1_rdata_i = rf(bus.reg1_raddr_o);
    assign bus.reg2_rdata_i = rf(bus.reg2_raddr_o);

    function automatic logic [31:0] rtype(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        logic [4:0] a, b, d;
        a = rs2[4:0];
        b = rs1[4:0];
        d = rd[4:0];
        return {f7, a, b, f3, d, OPC_OP};
    endfunction

    function automatic exp_t el(input logic [31:0] op1, input logic [31:0] op2,
                                input logic [4:0] waddr, input logic [4:0] alu,
                                input logic muldiv);
        exp_t e;
        e.illegal = 1'b0; e.op1 = op1; e.op2 = op2; e.we = (waddr != 5'd0);
        e.waddr = waddr; e.alu = alu; e.muldiv = muldiv;
        return e;
    endfunction

    function automatic exp_t ei();
        exp_t e;
        e.illegal = 1'b1; e.op1 = '0; e.op2 = '0; e.we = 1'b0;
        e.waddr = '0; e.alu = '0; e.muldiv = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every EX handshake pops one expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            if (exq.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = exq.pop_front();
                check("illegal", bus.illegal_o, e.illegal);
                check("reg_we", bus.reg_we_o, e.we);
                check("op1", bus.op1_o, e.op1);
                check("op2", bus.op2_o, e.op2);
                check("is_muldiv", bus.is_muldiv_o, e.muldiv);
                if (!e.illegal) begin
                    check("reg_waddr", bus.reg_waddr_o, e.waddr);
                    check("alu_op", bus.alu_op_o, e.alu);
                end
            end
        end
    end

    // Present inst until accepted (bounded); called and returns at posedge+1.
    task automatic send(input logic [31:0] inst, input bit push, input exp_t e, output int waited);
        waited = 0;
        bus.in_valid_i = 1'b1;
        bus.inst_i = inst;
        @(negedge clk);
        while (!bus.in_ready_o && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready_o) check("accept_timeout", bus.in_ready_o, 1'b1);
        else if (push) exq.push_back(e);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   w;
        int   c0;
        exp_t dummy;
        dummy = ei();
        bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.inst_i = '0;
        bus.out_ready_i = 1'b1; bus.wb_valid_i = 1'b0; bus.wb_waddr_i = '0;

        // Reset state
        idle(2);
        check("rst_out_valid", bus.out_valid_o, 1'b0);
        check("rst_op1", bus.op1_o, 32'd0);
        check("rst_reg_we", bus.reg_we_o, 1'b0);
        check("rst_alu_op", bus.alu_op_o, 5'd0);
        check("rst_illegal", bus.illegal_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready_o, 1'b1);
        check("rst_re", bus.reg1_re_o, 1'b0);
        @(posedge clk); #1;

        // add x3,x1,x2 with read-port checks
        bus.in_valid_i = 1'b1;
        bus.inst_i = rtype(F7_BASE, 2, 1, 3'b000, 3);
        @(negedge clk);
        check("raddr1", bus.reg1_raddr_o, 5'd1);
        check("raddr2", bus.reg2_raddr_o, 5'd2);
        check("re1", bus.reg1_re_o, 1'b1);
        check("add_ready", bus.in_ready_o, 1'b1);
        exq.push_back(el(32'd5, 32'd7, 5'd3, 5'b00000, 1'b0));
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        check("latency_valid", bus.out_valid_o, 1'b1);

        // Back-to-back sub / sra / xor at one per cycle
        c0 = cyc;
        send(rtype(F7_ALT, 2, 1, 3'b000, 6), 1, el(32'd5, 32'd7, 5'd6, 5'b01000, 1'b0), w);
        send(rtype(F7_ALT, 1, 2, 3'b101, 8), 1, el(32'd7, 32'd5, 5'd8, 5'b01101, 1'b0), w);
        send(rtype(F7_BASE, 4, 3, 3'b100, 9), 1, el(32'd300, 32'd400, 5'd9, 5'b00100, 1'b0), w);
        check("throughput_cycles", cyc - c0, 3);

        // Illegal funct7 encodings, then a reader of rd=12 must not stall
        send(rtype(7'b0000011, 2, 1, 3'b000, 12), 1, ei(), w);
        send(rtype(F7_ALT, 2, 1, 3'b001, 14), 1, ei(), w);
        send(rtype(F7_BASE, 12, 12, 3'b000, 13), 1, el(32'd1200, 32'd1200, 5'd13, 5'b00000, 1'b0), w);
        check("illegal_no_busy", w, 0);

        // Non-OP opcode: consumed with no output
        idle(2);
        bus.in_valid_i = 1'b1;
        bus.inst_i = {12'd5, 5'd1, 3'b000, 5'd15, 7'b0010011};
        @(negedge clk);
        check("nonop_re", bus.reg1_re_o, 1'b0);
        check("nonop_raddr", bus.reg1_raddr_o, 5'd0);
        check("nonop_ready", bus.in_ready_o, 1'b1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        check("nonop_no_out", bus.out_valid_o, 1'b0);
        @(posedge clk); #1;

        // Backpressure
        bus.out_ready_i = 1'b0;
        send(rtype(F7_ALT, 2, 1, 3'b000, 6), 1, el(32'd5, 32'd7, 5'd6, 5'b01000, 1'b0), w);
        bus.in_valid_i = 1'b1;
        bus.inst_i = rtype(F7_BASE, 1, 1, 3'b000, 10);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready_o, 1'b0);
            check("bp_valid", bus.out_valid_o, 1'b1);
            check("bp_op2", bus.op2_o, 32'd7);
            check("bp_waddr", bus.reg_waddr_o, 5'd6);
        end
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        send(rtype(F7_BASE, 1, 1, 3'b000, 10), 1, el(32'd5, 32'd5, 5'd10, 5'b00000, 1'b0), w);
        check("bp_release_same_cycle", w, 0);
        @(negedge clk);
        check("bp_reload_waddr", bus.reg_waddr_o, 5'd10);
        @(posedge clk); #1;

        // Flush with an accept pending
        idle(2);
        bus.in_valid_i = 1'b1;
        bus.inst_i = rtype(F7_BASE, 2, 1, 3'b000, 11);
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready_o, 1'b0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        check("flush_no_valid", bus.out_valid_o, 1'b0);
        @(posedge clk); #1;

        // Flush kills a stalled output
        bus.out_ready_i = 1'b0;
        send(rtype(F7_BASE, 2, 1, 3'b000, 12), 0, dummy, w);
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_kill", bus.out_valid_o, 1'b0);
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        idle(2);

        // x0 destination and mul handling
`ifdef ID_M_EXT_EN
        send(rtype(F7_MULDIV, 2, 1, 3'b000, 0), 1, el(32'd5, 32'd7, 5'd0, 5'b10000, 1'b1), w);
`else
        send(rtype(F7_MULDIV, 2, 1, 3'b000, 0), 1, ei(), w);
`endif
        send(rtype(F7_BASE, 0, 0, 3'b000, 7), 1, el(32'd0, 32'd0, 5'd7, 5'b00000, 1'b0), w);
        check("x0_no_stall", w, 0);

`ifdef ID_M_EXT_EN
        // RAW stall on mul x4 until write-back, no same-cycle bypass
        send(rtype(F7_MULDIV, 2, 1, 3'b000, 4), 1, el(32'd5, 32'd7, 5'd4, 5'b10000, 1'b1), w);
        bus.in_valid_i = 1'b1;
        bus.inst_i = rtype(F7_BASE, 1, 4, 3'b000, 5);
        repeat (3) begin
            @(negedge clk);
            check("raw_stall", bus.in_ready_o, 1'b0);
        end
        @(posedge clk); #1;
        bus.wb_valid_i = 1'b1;
        bus.wb_waddr_i = 5'd4;
        @(negedge clk);
        check("raw_no_bypass", bus.in_ready_o, 1'b0);
        @(posedge clk); #1;
        bus.wb_valid_i = 1'b0;
        send(rtype(F7_BASE, 1, 4, 3'b000, 5), 1, el(32'd400, 32'd5, 5'd5, 5'b00000, 1'b0), w);
        check("raw_release", w, 0);

        // WAW stall: sub x4 behind div x4
        send(rtype(F7_MULDIV, 2, 1, 3'b100, 4), 1, el(32'd5, 32'd7, 5'd4, 5'b10100, 1'b1), w);
        bus.in_valid_i = 1'b1;
        bus.inst_i = rtype(F7_ALT, 2, 1, 3'b000, 4);
        @(negedge clk);
        check("waw_stall", bus.in_ready_o, 1'b0);
        @(posedge clk); #1;
        bus.wb_valid_i = 1'b1;
        bus.wb_waddr_i = 5'd4;
        @(posedge clk); #1;
        bus.wb_valid_i = 1'b0;
        send(rtype(F7_ALT, 2, 1, 3'b000, 4), 1, el(32'd5, 32'd7, 5'd4, 5'b01000, 1'b0), w);
        check("waw_release", w, 0);
`else
        send(rtype(F7_MULDIV, 2, 1, 3'b000, 4), 1, ei(), w);
        send(rtype(F7_BASE, 1, 4, 3'b000, 5), 1, el(32'd400, 32'd5, 5'd5, 5'b00000, 1'b0), w);
        check("no_m_no_stall", w, 0);
`endif

        // Asynchronous reset while the output holds a mul (and busy[4] in the M build)
        idle(2);
        bus.out_ready_i = 1'b0;
        send(rtype(F7_MULDIV, 2, 1, 3'b000, 4), 0, dummy, w);
        check("pre_reset_valid", bus.out_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid_o, 1'b0);
        check("arst_op1", bus.op1_o, 32'd0);
        check("arst_we", bus.reg_we_o, 1'b0);
        check("arst_waddr", bus.reg_waddr_o, 5'd0);
        check("arst_muldiv", bus.is_muldiv_o, 1'b0);
        check("arst_illegal", bus.illegal_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        send(rtype(F7_BASE, 1, 4, 3'b000, 5), 1, el(32'd400, 32'd5, 5'd5, 5'b00000, 1'b0), w);
        check("arst_busy_cleared", w, 0);

        idle(3);
        check("queue_drained", exq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
